branch_rs: RTL and testbench

//  Branch reservation station between dispatch and the branch ALU (branchAlu) in the
//  out-of-order core. Holds branch uops until both source operands are known, snooping
//  the common data bus (CDB) for missing values. Issues one ready uop per cycle to an

---
 rtl/branch_rs_pkg.sv | 40 ++++
 rtl/branch_rs_alu.sv | 27 ++
 rtl/branch_rs.sv | 181 ++++++++++++++++++
 tb/tb_branch_rs.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_rs_pkg.sv
// Shared types and default sizes for the branch reservation station.
package branch_rs_pkg;

    localparam int NUM_ENTRIES_DEF = 4;
    localparam int TAG_W_DEF       = 4;
    localparam int XLEN_DEF        = 32;

    // Fall-through distance for a not-taken branch.
    localparam int PC_STEP = 4;

    // Branch comparison selector carried by every branch uop.
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NEQ = 3'd1,
        BR_LT  = 3'd2,
        BR_LTU = 3'd3,
        BR_GE  = 3'd4,
        BR_GEU = 3'd5,
        BR_DBR = 3'd6
    } br_func_e;

    // One source operand slot at the default widths: ready flag, value, producer tag.
    typedef struct packed {
        logic                 rdy;
        logic [XLEN_DEF-1:0]  val;
        logic [TAG_W_DEF-1:0] tag;
    } rs_src_t;

    // One station entry at the default widths.
    typedef struct packed {
        logic                 valid;
        br_func_e             func;
        logic [XLEN_DEF-1:0]  pc;
        logic [XLEN_DEF-1:0]  imm;
        logic [TAG_W_DEF-1:0] rob_tag;
        rs_src_t              src1;
        rs_src_t              src2;
    } rs_entry_t;

endpackage

// File: rtl/branch_rs_alu.sv
// Combinational branch condition evaluator (the branchAlu).
module branch_rs_alu
    import branch_rs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  br_func_e          func,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    output logic              taken
);

    // Evaluate the selected comparison; Dbr and unused codes never take.
    always_comb begin
        taken = 1'b0;
        case (func)
            BR_EQ:   taken = (src1 == src2);
            BR_NEQ:  taken = (src1 != src2);
            BR_LT:   taken = ($signed(src1) <  $signed(src2));
            BR_LTU:  taken = (src1 <  src2);
            BR_GE:   taken = ($signed(src1) >= $signed(src2));
            BR_GEU:  taken = (src1 >= src2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: buffers branch uops until both operands are known,
// snoops the CDB for missing operands, issues one ready uop per cycle into the
// branch ALU and holds the resolved branch in an output register.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where valid and
// ready are both high. Dispatch: disp_valid_in/disp_ready_out, disp_ready_out
// depends only on state, never on disp_valid_in. Result: res_valid_out/res_ready_in,
// res_* stay stable while res_valid_out && !res_ready_in, and a new result may
// replace the accepted one on the same edge.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int XLEN        = XLEN_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              flush_in,
    input  logic              disp_valid_in,
    output logic              disp_ready_out,
    input  logic [2:0]        disp_brFunc_in,
    input  logic [XLEN-1:0]   disp_pc_in,
    input  logic [XLEN-1:0]   disp_imm_in,
    input  logic [TAG_W-1:0]  disp_robTag_in,
    input  logic              disp_src1_rdy_in,
    input  logic [XLEN-1:0]   disp_src1_val_in,
    input  logic [TAG_W-1:0]  disp_src1_tag_in,
    input  logic              disp_src2_rdy_in,
    input  logic [XLEN-1:0]   disp_src2_val_in,
    input  logic [TAG_W-1:0]  disp_src2_tag_in,
    input  logic              cdb_valid_in,
    input  logic [TAG_W-1:0]  cdb_tag_in,
    input  logic [XLEN-1:0]   cdb_val_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [TAG_W-1:0]  res_robTag_out,
    output logic              res_taken_out,
    output logic [XLEN-1:0]   res_nextPc_out
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    // Entry layout sized by this instance's parameters.
    typedef struct packed {
        logic              rdy;
        logic [XLEN-1:0]   val;
        logic [TAG_W-1:0]  tag;
    } src_t;

    typedef struct packed {
        logic              valid;
        br_func_e          func;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [TAG_W-1:0]  rob_tag;
        src_t              src1;
        src_t              src2;
    } entry_t;

    entry_t            ent_q [NUM_ENTRIES];
    entry_t            disp_ent;
    logic              any_free;
    logic [IDX_W-1:0]  free_idx;
    logic              any_elig;
    logic [IDX_W-1:0]  issue_idx;
    logic              disp_fire;
    logic              issue_fire;
    logic              alu_taken;
    logic [XLEN-1:0]   alu_next_pc;

    // A waiting operand picks up the CDB value when its producer tag is broadcast.
    function automatic src_t snoop(input src_t s, input logic cv,
                                   input logic [TAG_W-1:0] ct, input logic [XLEN-1:0] cval);
        src_t r;
        r = s;
        if (!s.rdy && cv && (s.tag == ct)) begin
            r.rdy = 1'b1;
            r.val = cval;
        end
        return r;
    endfunction

    // Lowest-index free entry receives the next dispatched uop.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index entry whose operands were both ready at cycle start issues.
    always_comb begin
        any_elig  = 1'b0;
        issue_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy) begin
                any_elig  = 1'b1;
                issue_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready_out = any_free;
    assign disp_fire      = disp_valid_in && any_free && !flush_in;
    assign issue_fire     = any_elig && (!res_valid_out || res_ready_in) && !flush_in;

    // Build the incoming entry, including a same-cycle CDB wakeup of its sources.
    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.func     = br_func_e'(disp_brFunc_in);
        disp_ent.pc       = disp_pc_in;
        disp_ent.imm      = disp_imm_in;
        disp_ent.rob_tag  = disp_robTag_in;
        disp_ent.src1     = snoop({disp_src1_rdy_in, disp_src1_val_in, disp_src1_tag_in},
                                  cdb_valid_in, cdb_tag_in, cdb_val_in);
        disp_ent.src2     = snoop({disp_src2_rdy_in, disp_src2_val_in, disp_src2_tag_in},
                                  cdb_valid_in, cdb_tag_in, cdb_val_in);
    end

    branch_rs_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .func  (ent_q[issue_idx].func),
        .src1  (ent_q[issue_idx].src1.val),
        .src2  (ent_q[issue_idx].src2.val),
        .taken (alu_taken)
    );

    assign alu_next_pc = alu_taken ? (ent_q[issue_idx].pc + ent_q[issue_idx].imm)
                                   : (ent_q[issue_idx].pc + XLEN'(PC_STEP));

    // Entry storage: dispatch write, issue release and CDB capture; flush empties all.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (disp_fire && (free_idx == IDX_W'(i))) begin
                    ent_q[i] <= disp_ent;
                end else if (issue_fire && (issue_idx == IDX_W'(i))) begin
                    ent_q[i].valid <= 1'b0;
                end else if (ent_q[i].valid) begin
                    ent_q[i].src1 <= snoop(ent_q[i].src1, cdb_valid_in, cdb_tag_in, cdb_val_in);
                    ent_q[i].src2 <= snoop(ent_q[i].src2, cdb_valid_in, cdb_tag_in, cdb_val_in);
                end
            end
        end
    end

    // Result register: load on issue, drop when accepted with nothing behind it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_valid_out  <= 1'b0;
            res_robTag_out <= '0;
            res_taken_out  <= 1'b0;
            res_nextPc_out <= '0;
        end else if (flush_in) begin
            res_valid_out  <= 1'b0;
        end else if (issue_fire) begin
            res_valid_out  <= 1'b1;
            res_robTag_out <= ent_q[issue_idx].rob_tag;
            res_taken_out  <= alu_taken;
            res_nextPc_out <= alu_next_pc;
        end else if (res_ready_in) begin
            res_valid_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based station model.
module tb_branch_rs;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam int XL = 32;
    localparam int RW = TW + 1 + XL;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           disp_valid = 1'b0;
    logic           disp_ready;
    logic [2:0]     disp_func = '0;
    logic [XL-1:0]  disp_pc = '0;
    logic [XL-1:0]  disp_imm = '0;
    logic [TW-1:0]  disp_tag = '0;
    logic           s1_rdy = 1'b0;
    logic [XL-1:0]  s1_val = '0;
    logic [TW-1:0]  s1_tag = '0;
    logic           s2_rdy = 1'b0;
    logic [XL-1:0]  s2_val = '0;
    logic [TW-1:0]  s2_tag = '0;
    logic           cdb_valid = 1'b0;
    logic [TW-1:0]  cdb_tag = '0;
    logic [XL-1:0]  cdb_val = '0;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [TW-1:0]  res_tag;
    logic           res_taken;
    logic [XL-1:0]  res_npc;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: the resolved branch currently owed on the result port.
    logic [RW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    branch_rs #(.NUM_ENTRIES(N), .TAG_W(TW), .XLEN(XL)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .flush_in         (flush),
        .disp_valid_in    (disp_valid),
        .disp_ready_out   (disp_ready),
        .disp_brFunc_in   (disp_func),
        .disp_pc_in       (disp_pc),
        .disp_imm_in      (disp_imm),
        .disp_robTag_in   (disp_tag),
        .disp_src1_rdy_in (s1_rdy),
        .disp_src1_val_in (s1_val),
        .disp_src1_tag_in (s1_tag),
        .disp_src2_rdy_in (s2_rdy),
        .disp_src2_val_in (s2_val),
        .disp_src2_tag_in (s2_tag),
        .cdb_valid_in     (cdb_valid),
        .cdb_tag_in       (cdb_tag),
        .cdb_val_in       (cdb_val),
        .res_valid_out    (res_valid),
        .res_ready_in     (res_ready),
        .res_robTag_out   (res_tag),
        .res_taken_out    (res_taken),
        .res_nextPc_out   (res_npc)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit            v;
        logic [2:0]    f;
        logic [XL-1:0] pc;
        logic [XL-1:0] imm;
        logic [TW-1:0] tag;
        bit            r1;
        logic [XL-1:0] v1;
        logic [TW-1:0] t1;
        bit            r2;
        logic [XL-1:0] v2;
        logic [TW-1:0] t2;
    } m_ent_t;

    m_ent_t m [N];

    function automatic bit ref_taken(input logic [2:0] f, input logic [XL-1:0] a, input logic [XL-1:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < $signed(b);
            3'd3:    return a < b;
            3'd4:    return $signed(a) >= $signed(b);
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [RW-1:0] ref_result(input m_ent_t e);
        bit t;
        t = ref_taken(e.f, e.v1, e.v2);
        return {e.tag, t, t ? (e.pc + e.imm) : (e.pc + 32'd4)};
    endfunction

    task automatic model_edge();
        int fi;
        int ri;
        bit can_issue;
        if (!rst_n || flush) begin
            for (int i = 0; i < N; i++) m[i].v = 1'b0;
            exp_q.delete();
            return;
        end
        fi = -1;
        ri = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m[i].v) fi = i;
            if (m[i].v && m[i].r1 && m[i].r2) ri = i;
        end
        can_issue = (exp_q.size() == 0) || res_ready;
        if (exp_q.size() != 0 && res_ready) void'(exp_q.pop_front());
        if (ri >= 0 && can_issue) begin
            exp_q.push_back(ref_result(m[ri]));
            m[ri].v = 1'b0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < N; i++) begin
                if (m[i].v && !m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1'b1; m[i].v1 = cdb_val; end
                if (m[i].v && !m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1'b1; m[i].v2 = cdb_val; end
            end
        end
        if (disp_valid && fi >= 0) begin
            m[fi].v   = 1'b1;
            m[fi].f   = disp_func;
            m[fi].pc  = disp_pc;
            m[fi].imm = disp_imm;
            m[fi].tag = disp_tag;
            m[fi].r1  = s1_rdy;
            m[fi].v1  = s1_val;
            m[fi].t1  = s1_tag;
            m[fi].r2  = s2_rdy;
            m[fi].v2  = s2_val;
            m[fi].t2  = s2_tag;
            if (cdb_valid && !s1_rdy && s1_tag == cdb_tag) begin m[fi].r1 = 1'b1; m[fi].v1 = cdb_val; end
            if (cdb_valid && !s2_rdy && s2_tag == cdb_tag) begin m[fi].r2 = 1'b1; m[fi].v2 = cdb_val; end
        end
    endtask

    always @(posedge clk) model_edge();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic          e_rdy;
        logic          e_vld;
        logic [RW-1:0] e_res;
        logic [RW-1:0] g_res;
        if (rst_n) begin
            e_rdy = 1'b0;
            for (int i = 0; i < N; i++) if (!m[i].v) e_rdy = 1'b1;
            e_vld = (exp_q.size() != 0);
            e_res = e_vld ? exp_q[0] : '0;
            g_res = {res_tag, res_taken, res_npc};
            n_tests++;
            if (disp_ready !== e_rdy || res_valid !== e_vld || (e_vld && g_res !== e_res)) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t got rdy=%0b vld=%0b res=%0h, expected rdy=%0b vld=%0b res=%0h",
                         $time, disp_ready, res_valid, g_res, e_rdy, e_vld, e_res);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive_disp(input logic [2:0] f, input logic [XL-1:0] pc, input logic [XL-1:0] imm,
                              input logic [TW-1:0] tag,
                              input logic r1, input logic [XL-1:0] v1, input logic [TW-1:0] t1,
                              input logic r2, input logic [XL-1:0] v2, input logic [TW-1:0] t2);
        disp_valid = 1'b1;
        disp_func  = f;
        disp_pc    = pc;
        disp_imm   = imm;
        disp_tag   = tag;
        s1_rdy = r1; s1_val = v1; s1_tag = t1;
        s2_rdy = r2; s2_val = v2; s2_tag = t2;
    endtask

    task automatic drive_cdb(input logic [TW-1:0] t, input logic [XL-1:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_val   = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_disp_ready", 64'(disp_ready), 64'd1);
        chk("reset_res_valid", 64'(res_valid), 64'd0);
        chk("reset_res_npc", 64'(res_npc), 64'd0);

        // signed less-than, both operands ready
        drive_disp(3'd2, 32'h1000, 32'h20, 4'd3, 1'b1, 32'hFFFF_FFFB, 4'd0, 1'b1, 32'd10, 4'd0);
        cyc();
        idle();
        chk("lt_not_yet", 64'(res_valid), 64'd0);
        cyc();
        chk("lt_valid", 64'(res_valid), 64'd1);
        chk("lt_taken", 64'(res_taken), 64'd1);
        chk("lt_tag", 64'(res_tag), 64'd3);
        chk("lt_npc", 64'(res_npc), 64'h1020);

        // unsigned compare of the same values, then Dbr
        drive_disp(3'd3, 32'h2000, 32'h20, 4'd4, 1'b1, 32'hFFFF_FFFB, 4'd0, 1'b1, 32'd10, 4'd0);
        cyc();
        drive_disp(3'd6, 32'h3000, 32'h40, 4'd5, 1'b1, 32'd7, 4'd0, 1'b1, 32'd7, 4'd0);
        cyc();
        idle();
        chk("ltu_taken", 64'(res_taken), 64'd0);
        chk("ltu_npc", 64'(res_npc), 64'h2004);
        cyc();
        chk("dbr_tag", 64'(res_tag), 64'd5);
        chk("dbr_taken", 64'(res_taken), 64'd0);
        chk("dbr_npc", 64'(res_npc), 64'h3004);
        cyc();

        // wakeup through the CDB two cycles after dispatch
        drive_disp(3'd0, 32'h4000, 32'h10, 4'd6, 1'b1, 32'd12, 4'd0, 1'b0, 32'd0, 4'd5);
        cyc();
        idle();
        cyc();
        drive_cdb(4'd5, 32'd12);
        cyc();
        idle();
        chk("cdb_no_same_cycle_issue", 64'(res_valid), 64'd0);
        cyc();
        chk("cdb_wake_valid", 64'(res_valid), 64'd1);
        chk("cdb_wake_taken", 64'(res_taken), 64'd1);
        chk("cdb_wake_npc", 64'(res_npc), 64'h4010);
        cyc();

        // CDB broadcast in the dispatch cycle must not be lost
        drive_disp(3'd0, 32'h5000, 32'h8, 4'd7, 1'b1, 32'd12, 4'd0, 1'b0, 32'd0, 4'd5);
        drive_cdb(4'd5, 32'd12);
        cyc();
        idle();
        cyc();
        chk("disp_cdb_valid", 64'(res_valid), 64'd1);
        chk("disp_cdb_taken", 64'(res_taken), 64'd1);
        chk("disp_cdb_npc", 64'(res_npc), 64'h5008);

        // fill the station with waiting uops, then wake entry 2 only
        for (int i = 0; i < N; i++) begin
            drive_disp(3'd1, 32'h6000 + 32'(i * 16), 32'h100, 4'(8 + i),
                       1'b0, 32'd0, 4'(8 + i), 1'b1, 32'd0, 4'd0);
            cyc();
        end
        idle();
        chk("full_not_ready", 64'(disp_ready), 64'd0);
        drive_cdb(4'd10, 32'd5);
        cyc();
        idle();
        chk("full_after_capture", 64'(disp_ready), 64'd0);
        cyc();
        chk("full_ready_returns", 64'(disp_ready), 64'd1);
        chk("full_issue_tag", 64'(res_tag), 64'd10);
        chk("full_issue_npc", 64'(res_npc), 64'h6120);

        // flush with three waiting entries and a held result
        flush = 1'b1;
        cyc();
        idle();
        chk("flush_res_valid", 64'(res_valid), 64'd0);
        chk("flush_disp_ready", 64'(disp_ready), 64'd1);
        drive_cdb(4'd8, 32'd5);
        cyc();
        idle();
        cyc(2);
        chk("flush_entries_gone", 64'(res_valid), 64'd0);

        // back-pressure: result held, then released in index order
        res_ready = 1'b0;
        drive_disp(3'd5, 32'h7000, 32'h40, 4'd1, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0);
        cyc();
        drive_disp(3'd4, 32'h7100, 32'h40, 4'd2, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd0, 4'd0);
        cyc();
        drive_disp(3'd2, 32'h7200, 32'h80, 4'd3, 1'b1, 32'hFFFF_FFFF, 4'd0, 1'b1, 32'd0, 4'd0);
        cyc();
        idle();
        chk("hold_tag_a", 64'(res_tag), 64'd1);
        cyc();
        chk("hold_stable_tag", 64'(res_tag), 64'd1);
        chk("hold_stable_npc", 64'(res_npc), 64'h7040);
        res_ready = 1'b1;
        cyc();
        chk("drain_first_tag", 64'(res_tag), 64'd3);
        chk("drain_first_npc", 64'(res_npc), 64'h7280);
        cyc();
        chk("drain_second_tag", 64'(res_tag), 64'd2);
        chk("drain_second_taken", 64'(res_taken), 64'd0);
        chk("drain_second_npc", 64'(res_npc), 64'h7104);
        cyc();
        chk("drain_empty", 64'(res_valid), 64'd0);

        // asynchronous reset while a result is held
        res_ready = 1'b0;
        drive_disp(3'd0, 32'h8000, 32'h40, 4'd9, 1'b1, 32'd3, 4'd0, 1'b1, 32'd3, 4'd0);
        cyc();
        idle();
        cyc();
        chk("pre_reset_valid", 64'(res_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(res_valid), 64'd0);
        chk("async_rst_tag", 64'(res_tag), 64'd0);
        chk("async_rst_npc", 64'(res_npc), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        chk("post_rst_ready", 64'(disp_ready), 64'd1);

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            disp_valid = ($urandom_range(0, 99) < 60);
            disp_func  = 3'($urandom_range(0, 6));
            disp_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            disp_imm   = 32'($urandom_range(0, 64)) - 32'd32;
            disp_tag   = 4'($urandom_range(0, 15));
            s1_rdy     = ($urandom_range(0, 1) == 1);
            s1_val     = 32'($urandom_range(0, 4)) - 32'd2;
            s1_tag     = 4'($urandom_range(0, 7));
            s2_rdy     = ($urandom_range(0, 1) == 1);
            s2_val     = 32'($urandom_range(0, 4)) - 32'd2;
            s2_tag     = 4'($urandom_range(0, 7));
            cdb_valid  = ($urandom_range(0, 1) == 1);
            cdb_tag    = 4'($urandom_range(0, 7));
            cdb_val    = 32'($urandom_range(0, 4)) - 32'd2;
            res_ready  = ($urandom_range(0, 99) < 75);
            flush      = ($urandom_range(0, 99) == 0);
            cyc();
        end
        idle();
        res_ready = 1'b1;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
